// File: rtl/rx_pkg.sv
// ----------------------------------------------------------------------------
// rx_pkg
// Shared types and constants for the receive frame release path.
//   FCS_BYTES   : trailing frame check sequence bytes in every received frame
//   DESC_LEN_W  : width of the length field in a queued descriptor; the
//                 controller's LEN_W parameter must match it
//   rx_desc_t   : per-frame descriptor {bad, len}
//   rx_state_t  : release controller states
// ----------------------------------------------------------------------------
package rx_pkg;

    localparam int FCS_BYTES  = 4;
    localparam int DESC_LEN_W = 11;

    typedef struct packed {
        logic                  bad;
        logic [DESC_LEN_W-1:0] len;
    } rx_desc_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FWD,
        DISC
    } rx_state_t;

endpackage

// File: rtl/rx_frame_release_ctrl_if.sv
// ----------------------------------------------------------------------------
// rx_frame_release_ctrl_if
// Byte-level signals of the release controller: the read side of the MAC
// receive byte FIFO and the write side towards the L2-to-IP shim.
//   in_dout   : FIFO read data, valid the cycle after in_re
//   in_empty  : FIFO empty
//   in_re     : FIFO read enable
//   out_ready : sink can accept a byte
//   out_data  : forwarded byte
//   out_we    : byte strobe
//   out_sof   : with out_we, first byte of a frame
//   out_eof   : with out_we, last byte of a frame
// master = the controller, slave = the FIFO/sink environment.
// ----------------------------------------------------------------------------
interface rx_frame_release_ctrl_if;

    logic [7:0] in_dout;
    logic       in_empty;
    logic       in_re;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_we;
    logic       out_sof;
    logic       out_eof;

    modport master (
        input  in_dout, in_empty, out_ready,
        output in_re, out_data, out_we, out_sof, out_eof
    );

    modport slave (
        output in_dout, in_empty, out_ready,
        input  in_re, out_data, out_we, out_sof, out_eof
    );

endinterface

// File: rtl/rx_desc_fifo.sv
// ----------------------------------------------------------------------------
// rx_desc_fifo
// Synchronous show-ahead FIFO of frame descriptors.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_desc (ignored when full unless popping too)
//   push_desc  : descriptor to store
//   pop        : discard the head entry (ignored when empty)
//   pop_desc   : head entry, valid while !empty
//   full/empty : occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// ----------------------------------------------------------------------------
module rx_desc_fifo
    import rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  rx_desc_t push_desc,
    input  logic     pop,
    output rx_desc_t pop_desc,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    rx_desc_t      mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_desc = mem[rd_ptr[AW-1:0]];

    // A pop frees the head slot before the push lands, so a full queue
    // still accepts a push in the same cycle as a pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_desc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/rx_frame_release_ctrl.sv
// ----------------------------------------------------------------------------
// rx_frame_release_ctrl
// Drains the MAC receive byte FIFO one frame at a time, driven by a queue of
// per-frame descriptors {bad, len}. Good frames are forwarded with SOF/EOF
// markers, bad frames are read out and discarded, so a bad frame never leaks
// bytes downstream.
//   clk, rst_n    : clock, asynchronous active-low reset
//   fr_len        : frame bytes in the FIFO (FCS included), valid with a pulse
//   crc_ok_pulse  : frame ended, CRC good
//   crc_bad_pulse : frame ended, CRC bad (wins if both pulse together)
//   bus           : FIFO read side and sink write side (master modport)
//   err_overflow  : sticky, a descriptor arrived while the queue was full
//   cnt_ok        : frames forwarded (wraps)
//   cnt_drop      : frames discarded (wraps)
// Build option RX_FCS_STRIP_EN: when defined, the 4 FCS bytes of good frames
// are read and discarded instead of forwarded; good frames of 4 bytes or
// fewer then become drops.
// ----------------------------------------------------------------------------
module rx_frame_release_ctrl
    import rx_pkg::*;
#(
    parameter int LEN_W      = DESC_LEN_W,
    parameter int DESC_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LEN_W-1:0]      fr_len,
    input  logic                  crc_ok_pulse,
    input  logic                  crc_bad_pulse,
    rx_frame_release_ctrl_if.master bus,
    output logic                  err_overflow,
    output logic [15:0]           cnt_ok,
    output logic [15:0]           cnt_drop
);

    rx_state_t        state;
    rx_state_t        next_state;
    rx_desc_t         push_desc;
    rx_desc_t         pop_desc;
    logic             desc_push;
    logic             desc_pop;
    logic             q_full;
    logic             q_empty;

    logic             cur_bad;
    logic [LEN_W-1:0] cur_len;
    logic [LEN_W-1:0] load_fwd;
    logic [LEN_W-1:0] load_disc;
    logic [LEN_W-1:0] fwd_cnt;
    logic [LEN_W-1:0] disc_cnt;
    logic             fwd_frame;
    logic             first_pending;
    logic             rd_en;
    logic             fwd_rd;
    logic             frame_done;
    logic             out_we_q;
    logic             out_sof_q;
    logic             out_eof_q;

    assign desc_push = crc_ok_pulse | crc_bad_pulse;
    assign push_desc = '{bad: crc_bad_pulse, len: DESC_LEN_W'(fr_len)};
    assign desc_pop  = (state == IDLE) && !q_empty;

    rx_desc_fifo #(
        .DEPTH     (DESC_DEPTH)
    ) u_desc_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (desc_push),
        .push_desc (push_desc),
        .pop       (desc_pop),
        .pop_desc  (pop_desc),
        .full      (q_full),
        .empty     (q_empty)
    );

    // Split of the current frame into forwarded and discarded bytes.
    // A zero-length frame yields 0/0 and is retired straight from LOAD.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        load_fwd  = '0;
        load_disc = '0;
`ifdef RX_FCS_STRIP_EN
        if (!cur_bad && cur_len > LEN_W'(FCS_BYTES)) begin
            load_fwd  = cur_len - LEN_W'(FCS_BYTES);
            load_disc = LEN_W'(FCS_BYTES);
        end else begin
            load_disc = cur_len;
        end
`else
        if (!cur_bad) begin
            load_fwd  = cur_len;
        end else begin
            load_disc = cur_len;
        end
`endif
    end

    always_comb begin
        next_state = state;
        rd_en      = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (!q_empty) next_state = LOAD;
            end
            LOAD: begin
                if (load_fwd != '0)       next_state = FWD;
                else if (load_disc != '0) next_state = DISC;
                else                      next_state = IDLE;
            end
            FWD: begin
                // Reads only while the sink is ready; the byte lands one
                // cycle later, which the sink absorbs as one byte of skid.
                rd_en = !bus.in_empty && bus.out_ready;
                if (rd_en && fwd_cnt == LEN_W'(1)) begin
                    if (disc_cnt != '0) begin
                        next_state = DISC;
                    end else begin
                        next_state = IDLE;
                        frame_done = 1'b1;
                    end
                end
            end
            DISC: begin
                rd_en = !bus.in_empty;
                if (rd_en && disc_cnt == LEN_W'(1)) begin
                    next_state = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign fwd_rd = rd_en && (state == FWD);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_bad       <= 1'b0;
            cur_len       <= '0;
            fwd_cnt       <= '0;
            disc_cnt      <= '0;
            fwd_frame     <= 1'b0;
            first_pending <= 1'b0;
            out_we_q      <= 1'b0;
            out_sof_q     <= 1'b0;
            out_eof_q     <= 1'b0;
            err_overflow  <= 1'b0;
            cnt_ok        <= '0;
            cnt_drop      <= '0;
        end else begin
            out_we_q  <= fwd_rd;
            out_sof_q <= fwd_rd && first_pending;
            out_eof_q <= fwd_rd && (fwd_cnt == LEN_W'(1));

            if (desc_pop) begin
                cur_bad <= pop_desc.bad;
                cur_len <= LEN_W'(pop_desc.len);
            end

            // Sticky: a lost descriptor leaves the byte FIFO misaligned.
            if (desc_push && q_full && !desc_pop) begin
                err_overflow <= 1'b1;
            end

            case (state)
                LOAD: begin
                    fwd_cnt       <= load_fwd;
                    disc_cnt      <= load_disc;
                    fwd_frame     <= (load_fwd != '0);
                    first_pending <= 1'b1;
                    if (load_fwd == '0 && load_disc == '0) begin
                        cnt_drop <= cnt_drop + 16'd1;
                    end
                end
                FWD: begin
                    if (rd_en) begin
                        fwd_cnt       <= fwd_cnt - LEN_W'(1);
                        first_pending <= 1'b0;
                    end
                end
                DISC: begin
                    if (rd_en) disc_cnt <= disc_cnt - LEN_W'(1);
                end
                default: ;
            endcase

            if (frame_done) begin
                if (fwd_frame) cnt_ok   <= cnt_ok + 16'd1;
                else           cnt_drop <= cnt_drop + 16'd1;
            end
        end
    end

    // FIFO data is already registered and valid the cycle after the read,
    // so it passes straight through, gated to zero when no byte is strobed.
    assign bus.in_re    = rd_en;
    assign bus.out_we   = out_we_q;
    assign bus.out_sof  = out_sof_q;
    assign bus.out_eof  = out_eof_q;
    assign bus.out_data = out_we_q ? bus.in_dout : 8'h00;

endmodule

// File: tb/tb_rx_frame_release_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rx_frame_release_ctrl
// Self-checking bench for rx_frame_release_ctrl. A byte-FIFO model feeds the
// DUT; every forwarded byte is pushed to a scoreboard when its frame is
// loaded and popped when the DUT strobes it. Honors RX_FCS_STRIP_EN.
// ----------------------------------------------------------------------------
module tb_rx_frame_release_ctrl;
    import rx_pkg::*;

    localparam int LEN_W = 11;

    logic             clk;
    logic             rst_n;
    logic [LEN_W-1:0] fr_len;
    logic             crc_ok_pulse;
    logic             crc_bad_pulse;
    logic             err_overflow;
    logic [15:0]      cnt_ok;
    logic [15:0]      cnt_drop;

    rx_frame_release_ctrl_if bus_if ();

    rx_frame_release_ctrl #(
        .LEN_W         (LEN_W),
        .DESC_DEPTH    (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fr_len        (fr_len),
        .crc_ok_pulse  (crc_ok_pulse),
        .crc_bad_pulse (crc_bad_pulse),
        .bus           (bus_if),
        .err_overflow  (err_overflow),
        .cnt_ok        (cnt_ok),
        .cnt_drop      (cnt_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- byte FIFO model ----------------
    logic [7:0] fifo_mem [0:1023];
    int         wr_idx = 0;
    int         rd_idx = 0;
    logic       hold_empty = 1'b0;
    bit         underflow = 1'b0;

    assign bus_if.in_empty = hold_empty || (rd_idx == wr_idx);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx         <= wr_idx;
            bus_if.in_dout <= 8'h00;
        end else if (bus_if.in_re) begin
            if (rd_idx == wr_idx) begin
                underflow <= 1'b1;
            end else begin
                bus_if.in_dout <= fifo_mem[rd_idx];
                rd_idx         <= rd_idx + 1;
            end
        end
    end

    int   cyc = 0;
    logic last_ready = 1'b1;
    always @(posedge clk) begin
        cyc        <= cyc + 1;
        last_ready <= bus_if.out_ready;
    end

    // ---------------- scoreboard / bookkeeping ----------------
    logic [9:0] exp_mem [0:1023];
    int         exp_wr = 0;
    int         exp_rd = 0;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         out_seen = 0;
    int         first_re_cyc = 0;
    int         last_re_cyc = 0;
    bit         re_seen = 1'b0;
    int         pulse_cyc = 0;
    logic       ready_level = 1'b1;
    logic       toggle_ready = 1'b0;
    int         exp_ok = 0;
    int         exp_drop = 0;

    typedef struct {
        bit ok_p;
        bit bad_p;
        int len;
        int fwd_strip;
        int fwd_full;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int fwd_model(input bit bad, input int len);
`ifdef RX_FCS_STRIP_EN
        return (bad || len <= FCS_BYTES) ? 0 : len - FCS_BYTES;
`else
        return bad ? 0 : len;
`endif
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Writes a frame into the byte FIFO and queues its forwarded bytes.
    task automatic load_frame(input int len, input int fwd_n);
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            fifo_mem[wr_idx + i] = b;
            if (i < fwd_n) begin
                exp_mem[exp_wr] = {(i == 0), (i == fwd_n - 1), b};
                exp_wr++;
            end
        end
        wr_idx = wr_idx + len;
    endtask

    task automatic pulse(input bit ok, input bit bad, input int len);
        fr_len        = LEN_W'(len);
        crc_ok_pulse  = ok;
        crc_bad_pulse = bad;
        pulse_cyc     = cyc;
        tick();
    endtask

    task automatic clear_pulse();
        crc_ok_pulse  = 1'b0;
        crc_bad_pulse = 1'b0;
        fr_len        = '0;
    endtask

    task automatic wait_total(input int target, input int budget);
        int n = 0;
        while ((int'(cnt_ok) + int'(cnt_drop)) != target && n < budget) begin
            tick();
            n++;
        end
        check("frame retired within cycle budget", int'(n < budget), 1);
        repeat (3) tick();
    endtask

    task automatic check_counts(input string tag);
        check({tag, " cnt_ok"}, int'(cnt_ok), exp_ok);
        check({tag, " cnt_drop"}, int'(cnt_drop), exp_drop);
        check({tag, " scoreboard drained"}, exp_wr - exp_rd, 0);
    endtask

    initial begin
        int fwd_n;
        int start_rd;
        int start_out;
        int p0;
        int n;

        vecs[0] = '{1'b1, 1'b0, 64, 60, 64};
        vecs[1] = '{1'b0, 1'b1, 20,  0,  0};
        vecs[2] = '{1'b1, 1'b0, 10,  6, 10};
        vecs[3] = '{1'b0, 1'b1,  8,  0,  0};
        vecs[4] = '{1'b1, 1'b0,  5,  1,  5};
        vecs[5] = '{1'b1, 1'b0,  4,  0,  4};
        vecs[6] = '{1'b1, 1'b0,  1,  0,  1};
        vecs[7] = '{1'b1, 1'b0,  0,  0,  0};
        vecs[8] = '{1'b1, 1'b1, 12,  0,  0};

        rst_n            = 1'b0;
        bus_if.out_ready = 1'b1;
        clear_pulse();

        // Output monitor: samples on the falling edge, then drives out_ready.
        fork
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    exp_rd = exp_wr;
                end else begin
                    if (bus_if.in_re) begin
                        if (!re_seen) first_re_cyc = cyc;
                        last_re_cyc = cyc;
                        re_seen     = 1'b1;
                    end
                    if (bus_if.out_we) begin
                        out_seen++;
                        check("out_we follows a cycle with out_ready high", int'(last_ready), 1);
                        check("scoreboard has an expected byte", int'(exp_rd != exp_wr), 1);
                        if (exp_rd != exp_wr) begin
                            check("out byte {sof,eof,data}",
                                  int'({bus_if.out_sof, bus_if.out_eof, bus_if.out_data}),
                                  int'(exp_mem[exp_rd]));
                            exp_rd++;
                        end
                    end
                end
                bus_if.out_ready = toggle_ready ? ~bus_if.out_ready : ready_level;
            end
        join_none

        repeat (3) tick();
        check("reset in_re", int'(bus_if.in_re), 0);
        check("reset out_we", int'(bus_if.out_we), 0);
        check("reset out_sof", int'(bus_if.out_sof), 0);
        check("reset out_eof", int'(bus_if.out_eof), 0);
        check("reset out_data", int'(bus_if.out_data), 0);
        check("reset err_overflow", int'(err_overflow), 0);
        check("reset cnt_ok", int'(cnt_ok), 0);
        check("reset cnt_drop", int'(cnt_drop), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // ---------------- single-frame vectors ----------------
        for (int i = 0; i < 9; i++) begin
`ifdef RX_FCS_STRIP_EN
            fwd_n = vecs[i].fwd_strip;
`else
            fwd_n = vecs[i].fwd_full;
`endif
            start_rd = rd_idx;
            load_frame(vecs[i].len, fwd_n);
            repeat (2) tick();
            re_seen = 1'b0;
            pulse(vecs[i].ok_p, vecs[i].bad_p, vecs[i].len);
            clear_pulse();
            if (fwd_n > 0) exp_ok++;
            else           exp_drop++;
            wait_total(exp_ok + exp_drop, 400);
            check($sformatf("vec%0d reads", i), rd_idx - start_rd, vecs[i].len);
            check_counts($sformatf("vec%0d", i));
            if (vecs[i].len > 0) begin
                check($sformatf("vec%0d first in_re latency", i), first_re_cyc - pulse_cyc, 3);
            end
        end

        // ---------------- back-to-back: ok 10, bad 8, ok 5 ----------------
        start_rd = rd_idx;
        load_frame(10, fwd_model(1'b0, 10));
        load_frame(8, 0);
        load_frame(5, fwd_model(1'b0, 5));
        repeat (2) tick();
        re_seen = 1'b0;
        pulse(1'b1, 1'b0, 10);
        p0 = pulse_cyc;
        pulse(1'b0, 1'b1, 8);
        pulse(1'b1, 1'b0, 5);
        clear_pulse();
        exp_ok   += 2;
        exp_drop += 1;
        wait_total(exp_ok + exp_drop, 400);
        check("b2b reads", rd_idx - start_rd, 23);
        check("b2b first in_re latency", first_re_cyc - p0, 3);
        check("b2b read span (2-cycle gaps)", last_re_cyc - first_re_cyc + 1, 27);
        check_counts("b2b");

        // ---------------- out_ready toggling on a 64-byte good frame ----------------
        start_rd  = rd_idx;
        start_out = out_seen;
        fwd_n     = fwd_model(1'b0, 64);
        load_frame(64, fwd_n);
        toggle_ready = 1'b1;
        repeat (2) tick();
        pulse(1'b1, 1'b0, 64);
        clear_pulse();
        exp_ok++;
        wait_total(exp_ok + exp_drop, 800);
        toggle_ready = 1'b0;
        repeat (2) tick();
        check("toggle reads", rd_idx - start_rd, 64);
        check("toggle bytes out", out_seen - start_out, fwd_n);
        check_counts("toggle");

        // ---------------- descriptor queue overflow ----------------
        // The first descriptor is taken by the FSM, which then stalls on the
        // empty FIFO; the next four fill the queue and the fifth overflows.
        hold_empty = 1'b1;
        start_rd   = rd_idx;
        pulse(1'b1, 1'b0, 8);
        clear_pulse();
        repeat (4) tick();
        pulse(1'b1, 1'b0, 6);
        pulse(1'b1, 1'b0, 7);
        pulse(1'b1, 1'b0, 9);
        pulse(1'b1, 1'b0, 10);
        clear_pulse();
        tick();
        check("err_overflow before queue overflow", int'(err_overflow), 0);
        pulse(1'b0, 1'b1, 12);
        clear_pulse();
        tick();
        check("err_overflow after queue overflow", int'(err_overflow), 1);
        load_frame(8, fwd_model(1'b0, 8));
        load_frame(6, fwd_model(1'b0, 6));
        load_frame(7, fwd_model(1'b0, 7));
        load_frame(9, fwd_model(1'b0, 9));
        load_frame(10, fwd_model(1'b0, 10));
        hold_empty = 1'b0;
        exp_ok += 5;
        wait_total(exp_ok + exp_drop, 400);
        repeat (30) tick();
        check("overflow reads", rd_idx - start_rd, 40);
        check("overflow err sticky", int'(err_overflow), 1);
        check_counts("overflow");

        // ---------------- reset at byte 30 of a good frame ----------------
        start_out = out_seen;
        load_frame(64, fwd_model(1'b0, 64));
        repeat (2) tick();
        pulse(1'b1, 1'b0, 64);
        clear_pulse();
        n = 0;
        while ((out_seen - start_out) < 30 && n < 300) begin
            tick();
            n++;
        end
        check("reached byte 30 before reset", out_seen - start_out, 30);
        rst_n = 1'b0;
        #1;
        check("mid-frame reset in_re", int'(bus_if.in_re), 0);
        check("mid-frame reset out_we", int'(bus_if.out_we), 0);
        check("mid-frame reset out_sof", int'(bus_if.out_sof), 0);
        check("mid-frame reset out_eof", int'(bus_if.out_eof), 0);
        check("mid-frame reset out_data", int'(bus_if.out_data), 0);
        check("mid-frame reset err_overflow", int'(err_overflow), 0);
        check("mid-frame reset cnt_ok", int'(cnt_ok), 0);
        check("mid-frame reset cnt_drop", int'(cnt_drop), 0);
        repeat (3) tick();
        rst_n    = 1'b1;
        exp_ok   = 0;
        exp_drop = 0;
        repeat (2) tick();

        start_rd  = rd_idx;
        start_out = out_seen;
        fwd_n     = fwd_model(1'b0, 64);
        load_frame(64, fwd_n);
        repeat (2) tick();
        pulse(1'b1, 1'b0, 64);
        clear_pulse();
        exp_ok++;
        wait_total(exp_ok + exp_drop, 400);
        check("post-reset reads", rd_idx - start_rd, 64);
        check("post-reset bytes out", out_seen - start_out, fwd_n);
        check_counts("post-reset");

        check("no read from an empty FIFO", int'(underflow), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
